// File: rtl/usb_ep_buf_arbiter.sv
// Arbitrates the single-port USB endpoint buffer RAM between the SIE and the CPU.
// SIE has priority; a wait counter bounds how long a contending CPU access can starve.
module usb_ep_buf_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CPU_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sie_req,
  input  logic              sie_we,
  input  logic [ADDR_W-1:0] sie_addr,
  input  logic [DATA_W-1:0] sie_wdata,
  output logic              sie_gnt,
  output logic              sie_rvalid,
  output logic [DATA_W-1:0] sie_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned WCNT_W = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;
  localparam bit                GUARD_EN   = (CPU_MAX_WAIT != 0);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {
    CPU_IDLE,
    CPU_WAIT,
    CPU_ACK
  } cpu_state_e;

  cpu_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              sie_rvalid_q, sie_rvalid_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] sie_rdata_q, sie_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic sie_act;
  logic cpu_pend;
  logic sel_sie;
  logic sel_cpu;

  // Requests are masked while reset is low so the combinational RAM side goes quiet at once.
  always_comb begin
    sie_act  = sie_req && reset;
    cpu_pend = cpu_req && reset && (state_q != CPU_ACK);
    sel_sie  = 1'b0;
    sel_cpu  = 1'b0;
    if (sie_act && cpu_pend) begin
      if (GUARD_EN && (wait_cnt_q >= WAIT_LIMIT)) begin
        sel_cpu = 1'b1;
      end else begin
        sel_sie = 1'b1;
      end
    end else if (sie_act) begin
      sel_sie = 1'b1;
    end else if (cpu_pend) begin
      sel_cpu = 1'b1;
    end
  end

  always_comb begin
    ram_en    = sel_sie || sel_cpu;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (sel_sie) begin
      ram_we    = sie_we;
      ram_addr  = sie_addr;
      ram_wdata = sie_wdata;
    end else if (sel_cpu) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  assign sie_gnt = sel_sie;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CPU_IDLE: begin
        if (cpu_pend) begin
          state_d = sel_cpu ? CPU_ACK : CPU_WAIT;
        end
      end
      CPU_WAIT: begin
        if (sel_cpu) begin
          state_d = CPU_ACK;
        end
      end
      CPU_ACK: begin
        state_d = CPU_IDLE;
      end
      default: begin
        state_d = CPU_IDLE;
      end
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (sel_cpu) begin
      wait_cnt_d = '0;
    end else if (sel_sie && cpu_pend && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Read data passes straight through in the response cycle, then is held for the requester.
  always_comb begin
    sie_rvalid_d = sel_sie && !sie_we;
    cpu_rd_d     = sel_cpu && !cpu_we;
    sie_rdata_d  = sie_rvalid_q ? ram_rdata : sie_rdata_q;
    cpu_rdata_d  = ((state_q == CPU_ACK) && cpu_rd_q) ? ram_rdata : cpu_rdata_q;
  end

  assign sie_rvalid = sie_rvalid_q;
  assign sie_rdata  = sie_rdata_d;
  assign cpu_ack    = (state_q == CPU_ACK);
  assign cpu_rdata  = cpu_rdata_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CPU_IDLE;
      wait_cnt_q   <= '0;
      sie_rvalid_q <= 1'b0;
      cpu_rd_q     <= 1'b0;
      sie_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      sie_rvalid_q <= sie_rvalid_d;
      cpu_rd_q     <= cpu_rd_d;
      sie_rdata_q  <= sie_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!reset) !(sel_sie && sel_cpu));
  a_ack_pulse: assert property (@(posedge clk) disable iff (!reset) cpu_ack |=> !cpu_ack);
  a_no_ack_access: assert property (@(posedge clk) disable iff (!reset) cpu_ack |-> !sel_cpu);

endmodule
